// File: rtl/grayscale_frame_ctrl_if.sv
// AXI-Stream style channel (data, valid, ready, last) shared by the RGB source
// and the gray result sink of the grayscale frame controller.
interface grayscale_frame_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/grayscale_frame_ctrl.sv
// Frame sequencer: meters RGB pixels into a fixed-latency grayscale pipe, buffers
// results in a credit-protected FIFO and re-emits them as a stream with TLAST.
module grayscale_frame_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 24,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   cfg_start,
    input  logic                   cfg_abort,
    input  logic [CNT_WIDTH-1:0]   cfg_pixel_count,
    output logic                   status_busy,
    output logic                   status_done,
    output logic                   status_err,
    output logic                   irq,
    grayscale_frame_ctrl_if.slave  s_rgb,
    output logic [DATA_WIDTH-1:0]  pipe_in_data,
    output logic                   pipe_in_valid,
    input  logic [DATA_WIDTH-1:0]  pipe_out_data,
    input  logic                   pipe_out_valid,
    grayscale_frame_ctrl_if.master m_gray
);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0]        FIFO_FULL = OW'(MAX_INFLIGHT);
    localparam logic [OW:0]          OCC_MAX   = (OW + 1)'(MAX_INFLIGHT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ABORT} state_e;

    state_e                 state_q,    state_d;
    logic [CNT_WIDTH-1:0]   count_q,    count_d;
    logic [CNT_WIDTH-1:0]   issued_q,   issued_d;
    logic [CNT_WIDTH-1:0]   sent_q,     sent_d;
    logic [OW-1:0]          inflight_q, inflight_d;
    logic [OW-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]          wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q,   rd_ptr_d;
    logic                   done_q,     done_d;
    logic                   err_q,      err_d;
    logic                   irq_q,      irq_d;
    logic                   pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]  pipe_dat_q, pipe_dat_d;
    logic [DATA_WIDTH-1:0]  mem_q [MAX_INFLIGHT];

    logic [OW:0] occupancy;
    logic        fifo_full;
    logic        src_ready;
    logic        issue;
    logic        out_valid;
    logic        pop;
    logic        push;
    logic        pipe_ret;

    // Handshake qualifiers; credits cover both the pipe and the FIFO so a push can never be refused.
    always_comb begin
        occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
        fifo_full = (fifo_cnt_q == FIFO_FULL);
        src_ready = (state_q == RUN) && (occupancy < OCC_MAX) && (issued_q < count_q);
        issue     = src_ready && s_rgb.tvalid;
        out_valid = (fifo_cnt_q != '0);
        pop       = out_valid && m_gray.tready;
        push      = pipe_out_valid && (!fifo_full || pop);
        pipe_ret  = pipe_out_valid && (inflight_q != '0);
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        issued_d   = issued_q;
        sent_d     = sent_q;
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        done_d     = done_q;
        err_d      = err_q;
        irq_d      = 1'b0;
        pipe_vld_d = issue;
        pipe_dat_d = issue ? s_rgb.tdata : pipe_dat_q;

        if (issue) begin
            issued_d = issued_q + CNT_ONE;
            if (s_rgb.tlast != (issued_q == count_q - CNT_ONE)) err_d = 1'b1;
        end
        if (pop) begin
            sent_d   = sent_q + CNT_ONE;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pipe_out_valid && fifo_full && !pop) err_d = 1'b1;

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + OW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - OW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({issue, pipe_ret})
            2'b10:   inflight_d = inflight_q + OW'(1);
            2'b01:   inflight_d = inflight_q - OW'(1);
            default: inflight_d = inflight_q;
        endcase

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_pixel_count != '0) begin
                        count_d  = cfg_pixel_count;
                        issued_d = '0;
                        sent_d   = '0;
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        state_d  = RUN;
                    end else begin
                        err_d = 1'b1;
                        irq_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cfg_abort)                                   state_d = ABORT;
                else if (issue && (issued_q + CNT_ONE == count_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (cfg_abort) begin
                    state_d = ABORT;
                end else if (sent_q == count_q) begin
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            ABORT: begin
                if (inflight_q == '0 && fifo_cnt_q == '0) begin
                    err_d   = 1'b1;
                    irq_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            count_q    <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            pipe_vld_q <= 1'b0;
            pipe_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_dat_q <= pipe_dat_d;
        end
    end

    // NOTE: FIFO storage is not reset; fifo_cnt_q says what is valid and tdata is masked while empty.
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= pipe_out_data;
    end

    assign status_busy   = (state_q != IDLE);
    assign status_done   = done_q;
    assign status_err    = err_q;
    assign irq           = irq_q;
    assign s_rgb.tready  = src_ready;
    assign pipe_in_valid = pipe_vld_q;
    assign pipe_in_data  = pipe_dat_q;
    assign m_gray.tvalid = out_valid;
    assign m_gray.tdata  = out_valid ? mem_q[rd_ptr_q] : '0;
    // An aborted frame never reaches its last beat, so TLAST is suppressed while draining.
    assign m_gray.tlast  = out_valid && (state_q != ABORT) && (sent_q == count_q - CNT_ONE);
endmodule

// File: tb/tb_grayscale_frame_ctrl.sv
// Scoreboard bench for grayscale_frame_ctrl: a 4-stage pipe model, a stream source,
// and a monitor that pops expected beats whenever the result stream hands one over.
module tb_grayscale_frame_ctrl;
  localparam int DW = 32;
  localparam int CW = 24;
  localparam int MI = 8;
  localparam int PIPE_LAT = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cfg_start, cfg_abort;
  logic [CW-1:0] cfg_pixel_count;
  logic          status_busy, status_done, status_err, irq;
  logic [DW-1:0] pipe_in_data, pipe_out_data;
  logic          pipe_in_valid, pipe_out_valid;

  grayscale_frame_ctrl_if #(.DATA_WIDTH(DW)) s_rgb ();
  grayscale_frame_ctrl_if #(.DATA_WIDTH(DW)) m_gray ();

  int    n_cmp = 0, n_err = 0;
  int    n_beats = 0, n_irq = 0, n_pipe_issue = 0, n_issued = 0;
  bit    src_kill = 1'b0;
  beat_t exp_q[$];

  always #5 aclk = ~aclk;

  grayscale_frame_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_INFLIGHT(MI)) dut (
    .ACLK(aclk), .ARESET(areset),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_pixel_count(cfg_pixel_count),
    .status_busy(status_busy), .status_done(status_done), .status_err(status_err), .irq(irq),
    .s_rgb(s_rgb),
    .pipe_in_data(pipe_in_data), .pipe_in_valid(pipe_in_valid),
    .pipe_out_data(pipe_out_data), .pipe_out_valid(pipe_out_valid),
    .m_gray(m_gray)
  );

  function automatic logic [DW-1:0] gray(input logic [DW-1:0] p);
    int unsigned y;
    y = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
    return DW'(y);
  endfunction

  function automatic logic [DW-1:0] pix(input int f, input int i);
    logic [7:0] r, g, b;
    r = 8'(i * 7 + f * 31);
    g = 8'(i * 13 + 5);
    b = 8'(255 - i);
    return {8'hA5, r, g, b};
  endfunction

  // Grayscale pipe model: fixed latency, no backpressure, cleared by reset.
  logic [PIPE_LAT-1:0] pv;
  logic [DW-1:0]       pd [PIPE_LAT];
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      pv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[PIPE_LAT-2:0], pipe_in_valid};
      pd[0] <= gray(pipe_in_data);
      for (int i = 1; i < PIPE_LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign pipe_out_valid = pv[PIPE_LAT-1];
  assign pipe_out_data  = pd[PIPE_LAT-1];

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired before the awaited event", name);
  endtask

  // Monitor: samples on the falling edge, the handshake completes on the next rising edge.
  always @(negedge aclk) begin
    beat_t e;
    if (!areset && m_gray.tvalid && m_gray.tready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data %h, expected no beat", m_gray.tdata);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", m_gray.tdata, e.data);
        check("beat_last", DW'(m_gray.tlast), DW'(e.last));
      end
    end
    if (irq) n_irq++;
    if (pipe_in_valid) n_pipe_issue++;
  end

  task automatic start_frame(input int count);
    @(posedge aclk); #1;
    cfg_start = 1'b1;
    cfg_pixel_count = CW'(count);
    @(posedge aclk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_frame(input int frame, input int n_send, input int count, input int last_at);
    beat_t b;
    for (int i = 0; i < n_send; i++) begin
      int waited = 0;
      @(posedge aclk); #1;
      s_rgb.tvalid = 1'b1;
      s_rgb.tdata  = pix(frame, i);
      s_rgb.tlast  = (i == last_at);
      @(negedge aclk);
      while (!s_rgb.tready && !src_kill && waited < 2000) begin
        @(negedge aclk);
        waited++;
      end
      if (src_kill) break;
      if (waited >= 2000) begin
        fail("src_ready_timeout");
        break;
      end
      b.data = gray(pix(frame, i));
      b.last = (i == count - 1);
      exp_q.push_back(b);
      n_issued++;
    end
    @(posedge aclk); #1;
    s_rgb.tvalid = 1'b0;
    s_rgb.tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int waited = 0;
    @(negedge aclk);
    while (status_busy && waited < 3000) begin
      @(negedge aclk);
      waited++;
    end
    if (waited >= 3000) fail(name);
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    int b_irq, b_beats, b_issued, b_pipe;
    areset = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_pixel_count = '0;
    s_rgb.tvalid = 1'b0;
    s_rgb.tdata  = '0;
    s_rgb.tlast  = 1'b0;
    m_gray.tready = 1'b1;

    repeat (3) @(negedge aclk);
    check("rst_busy", DW'(status_busy), 0);
    check("rst_done", DW'(status_done), 0);
    check("rst_err", DW'(status_err), 0);
    check("rst_irq", DW'(irq), 0);
    check("rst_src_ready", DW'(s_rgb.tready), 0);
    check("rst_pipe_valid", DW'(pipe_in_valid), 0);
    check("rst_out_valid", DW'(m_gray.tvalid), 0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // T1: 16 pixels, free-flowing source and sink
    b_irq = n_irq; b_beats = n_beats;
    start_frame(16);
    send_frame(1, 16, 16, 15);
    wait_idle("t1_idle");
    check("t1_beats", DW'(n_beats - b_beats), 16);
    check("t1_done", DW'(status_done), 1);
    check("t1_err", DW'(status_err), 0);
    check("t1_irq", DW'(n_irq - b_irq), 1);
    check("t1_q_empty", DW'(exp_q.size()), 0);

    // T2: 32 pixels with the sink stalled for 40 cycles
    b_irq = n_irq; b_beats = n_beats; b_issued = n_issued;
    m_gray.tready = 1'b0;
    start_frame(32);
    fork
      send_frame(2, 32, 32, 31);
      begin
        repeat (40) @(negedge aclk);
        check("t2_stall_issued", DW'(n_issued - b_issued), 8);
        check("t2_stall_ready", DW'(s_rgb.tready), 0);
        check("t2_stall_out_valid", DW'(m_gray.tvalid), 1);
        check("t2_stall_err", DW'(status_err), 0);
        @(posedge aclk); #1;
        m_gray.tready = 1'b1;
      end
    join
    wait_idle("t2_idle");
    check("t2_beats", DW'(n_beats - b_beats), 32);
    check("t2_done", DW'(status_done), 1);
    check("t2_err", DW'(status_err), 0);
    check("t2_irq", DW'(n_irq - b_irq), 1);

    // T3: zero-count start with the source offering data
    b_irq = n_irq; b_pipe = n_pipe_issue;
    @(posedge aclk); #1;
    s_rgb.tvalid = 1'b1;
    s_rgb.tdata  = pix(3, 0);
    start_frame(0);
    repeat (4) @(negedge aclk);
    check("t3_err", DW'(status_err), 1);
    check("t3_busy", DW'(status_busy), 0);
    check("t3_ready", DW'(s_rgb.tready), 0);
    check("t3_irq", DW'(n_irq - b_irq), 1);
    check("t3_no_issue", DW'(n_pipe_issue - b_pipe), 0);
    @(posedge aclk); #1;
    s_rgb.tvalid = 1'b0;

    // T4: 100-pixel frame aborted after 20 issues
    b_irq = n_irq; b_beats = n_beats; b_pipe = n_pipe_issue;
    start_frame(100);
    send_frame(4, 20, 100, -1);
    cfg_abort = 1'b1;
    @(posedge aclk); #1;
    cfg_abort = 1'b0;
    s_rgb.tvalid = 1'b1;
    s_rgb.tdata  = pix(4, 20);
    wait_idle("t4_idle");
    s_rgb.tvalid = 1'b0;
    check("t4_pipe_issues", DW'(n_pipe_issue - b_pipe), 20);
    check("t4_beats", DW'(n_beats - b_beats), 20);
    check("t4_err", DW'(status_err), 1);
    check("t4_done", DW'(status_done), 0);
    check("t4_irq", DW'(n_irq - b_irq), 1);

    // T5: source tlast on pixel 5 of 8
    b_irq = n_irq; b_beats = n_beats;
    start_frame(8);
    send_frame(5, 8, 8, 4);
    wait_idle("t5_idle");
    check("t5_beats", DW'(n_beats - b_beats), 8);
    check("t5_err", DW'(status_err), 1);
    check("t5_done", DW'(status_done), 1);
    check("t5_irq", DW'(n_irq - b_irq), 1);

    // T6: reset in the middle of a running frame, then a clean 4-pixel frame
    start_frame(16);
    fork
      send_frame(6, 16, 16, 15);
      begin
        repeat (8) @(posedge aclk);
        #1 areset = 1'b1;
        #1;
        check("t6_busy", DW'(status_busy), 0);
        check("t6_done", DW'(status_done), 0);
        check("t6_err", DW'(status_err), 0);
        check("t6_irq", DW'(irq), 0);
        check("t6_ready", DW'(s_rgb.tready), 0);
        check("t6_pipe_valid", DW'(pipe_in_valid), 0);
        check("t6_out_valid", DW'(m_gray.tvalid), 0);
        check("t6_out_last", DW'(m_gray.tlast), 0);
        src_kill = 1'b1;
      end
    join
    exp_q.delete();
    src_kill = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    b_irq = n_irq; b_beats = n_beats;
    start_frame(4);
    send_frame(7, 4, 4, 3);
    wait_idle("t6_idle");
    check("t6_beats", DW'(n_beats - b_beats), 4);
    check("t6_frame_done", DW'(status_done), 1);
    check("t6_frame_err", DW'(status_err), 0);
    check("t6_frame_irq", DW'(n_irq - b_irq), 1);
    check("t6_q_empty", DW'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
